// File: rtl/sbus_arbiter_pkg.sv
// sbus_arbiter_pkg: shared widths and state/owner types for the ibus/dbus arbiter
package sbus_arbiter_pkg;
  localparam int SBUS_ADDR_W = 32;
  localparam int SBUS_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t;
  typedef enum logic {OWNER_I, OWNER_D} arb_owner_t;
endpackage

// File: rtl/sbus_arbiter_if.sv
// sbus_arbiter_if: simple request/ack bus with master and slave views
interface sbus_arbiter_if import sbus_arbiter_pkg::*; #(
  parameter int ADDR_W = SBUS_ADDR_W,
  parameter int DATA_W = SBUS_DATA_W
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wsel;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  modport master (output req, wr, addr, wdata, wsel, input rdata, ack);
  modport slave  (input req, wr, addr, wdata, wsel, output rdata, ack);
endinterface

// File: rtl/sbus_arbiter_arb_rr2.sv
// arb_rr2: two-input round-robin picker; on a tie the side not granted last wins
module arb_rr2 import sbus_arbiter_pkg::*; (
  input  logic [1:0] req,
  input  arb_owner_t last,
  output logic [1:0] gnt
);
  always_comb gnt = &req ? (last == OWNER_I ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/sbus_arbiter.sv
// sbus_arbiter: merges instruction and data buses onto one memory port, round-robin on contention
module sbus_arbiter import sbus_arbiter_pkg::*; #(
  parameter int ADDR_W = SBUS_ADDR_W,
  parameter int DATA_W = SBUS_DATA_W
) (
  input logic           clk,
  input logic           rst,
  sbus_arbiter_if.slave  ibus,
  sbus_arbiter_if.slave  dbus,
  sbus_arbiter_if.master mem
);
  arb_state_t          state, state_nxt;
  arb_owner_t          last;
  logic [1:0]          gnt;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wsel_q;
  logic                i_hit, d_hit;
  arb_rr2 u_rr (.req({dbus.req, ibus.req}), .last(last), .gnt(gnt));
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = gnt[1] ? GRANT_D : gnt[0] ? GRANT_I : IDLE;
    else if (mem.ack) state_nxt = IDLE;
    i_hit = state == GRANT_I && mem.ack;
    d_hit = state == GRANT_D && mem.ack;
    ibus.ack = i_hit;
    dbus.ack = d_hit;
    ibus.rdata = i_hit ? mem.rdata : '0;
    dbus.rdata = d_hit ? mem.rdata : '0;
  end
  // request fields are captured only at grant so the memory sees them stable until ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= OWNER_I;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wsel_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |gnt) begin
        last    <= gnt[1] ? OWNER_D : OWNER_I;
        wr_q    <= gnt[1] ? dbus.wr : ibus.wr;
        addr_q  <= gnt[1] ? dbus.addr : ibus.addr;
        wdata_q <= gnt[1] ? dbus.wdata : ibus.wdata;
        wsel_q  <= gnt[1] ? dbus.wsel : ibus.wsel;
      end
    end
  end
  assign mem.req   = state != IDLE;
  assign mem.wr    = wr_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign mem.wsel  = wsel_q;
endmodule

// File: tb/tb_sbus_arbiter.sv
// tb_sbus_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_sbus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  sbus_arbiter_if ib ();
  sbus_arbiter_if db ();
  sbus_arbiter_if mem ();
  sbus_arbiter dut (.clk(clk), .rst(rst), .ibus(ib), .dbus(db), .mem(mem));

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    ib.req = 0; ib.wr = 0; ib.addr = '0; ib.wdata = '0; ib.wsel = '0;
    db.req = 0; db.wr = 0; db.addr = '0; db.wdata = '0; db.wsel = '0;
    mem.ack = 0; mem.rdata = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    ib.req = 1; db.req = 1; mem.ack = 1; mem.rdata = '1;
    @(posedge clk);
    mid();
    n_cmp++; if ({mem.req, mem.wr, mem.addr, mem.wdata, mem.wsel} !== '0) begin n_err++; $display("FAIL reset_mem got %0h exp 0", {mem.req, mem.wr, mem.addr, mem.wdata, mem.wsel}); end
    n_cmp++; if ({ib.ack, db.ack, ib.rdata, db.rdata} !== '0) begin n_err++; $display("FAIL reset_resp got %0h exp 0", {ib.ack, db.ack, ib.rdata, db.rdata}); end
    next();
    drive_idle();
    rst = 0;
  endtask

  task automatic test_lone_read();
    next(); ib.req = 1; ib.wr = 0; ib.addr = 32'hBFC00000; ib.wsel = 4'hF;
    mid();
    n_cmp++; if (mem.req !== 1'b0) begin n_err++; $display("FAIL lone_idle got %0h exp 0", mem.req); end
    next(); mid();
    n_cmp++; if ({mem.req, mem.wr, mem.addr} !== {1'b1, 1'b0, 32'hBFC00000}) begin n_err++; $display("FAIL lone_grant got %0h exp %0h", {mem.req, mem.wr, mem.addr}, {1'b1, 1'b0, 32'hBFC00000}); end
    repeat (2) begin
      next(); mid();
      n_cmp++; if (ib.ack !== 1'b0) begin n_err++; $display("FAIL lone_wait_ack got %0h exp 0", ib.ack); end
    end
    next(); mem.ack = 1; mem.rdata = 32'h3C1DBFC0;
    mid();
    n_cmp++; if ({ib.ack, ib.rdata} !== {1'b1, 32'h3C1DBFC0}) begin n_err++; $display("FAIL lone_ack got %0h exp %0h", {ib.ack, ib.rdata}, {1'b1, 32'h3C1DBFC0}); end
    n_cmp++; if ({db.ack, db.rdata} !== '0) begin n_err++; $display("FAIL lone_d_quiet got %0h exp 0", {db.ack, db.rdata}); end
    next(); mem.ack = 0; mem.rdata = '0; ib.req = 0;
    mid();
    n_cmp++; if ({ib.ack, mem.req} !== 2'b00) begin n_err++; $display("FAIL lone_done got %0h exp 0", {ib.ack, mem.req}); end
  endtask

  task automatic test_tie();
    next(); ib.req = 1; ib.addr = 32'h40; db.req = 1; db.wr = 1; db.addr = 32'h80001000; db.wdata = 32'hDEADBEEF; db.wsel = 4'hF;
    next(); mid();
    n_cmp++; if ({mem.req, mem.wr, mem.addr, mem.wdata, mem.wsel} !== {1'b1, 1'b1, 32'h80001000, 32'hDEADBEEF, 4'hF}) begin n_err++; $display("FAIL tie_d_first got %0h exp %0h", {mem.req, mem.wr, mem.addr, mem.wdata, mem.wsel}, {1'b1, 1'b1, 32'h80001000, 32'hDEADBEEF, 4'hF}); end
    next(); mem.ack = 1; mem.rdata = 32'h55;
    mid();
    n_cmp++; if ({db.ack, ib.ack, ib.rdata} !== {1'b1, 1'b0, 32'h0}) begin n_err++; $display("FAIL tie_d_ack got %0h exp %0h", {db.ack, ib.ack, ib.rdata}, {1'b1, 1'b0, 32'h0}); end
    next(); mem.ack = 0; db.req = 0; db.wr = 0;
    mid();
    n_cmp++; if (mem.req !== 1'b0) begin n_err++; $display("FAIL tie_gap got %0h exp 0", mem.req); end
    next(); mid();
    n_cmp++; if ({mem.req, mem.wr, mem.addr} !== {1'b1, 1'b0, 32'h40}) begin n_err++; $display("FAIL tie_i_second got %0h exp %0h", {mem.req, mem.wr, mem.addr}, {1'b1, 1'b0, 32'h40}); end
    next(); mem.ack = 1; mem.rdata = 32'h1234;
    mid();
    n_cmp++; if ({ib.ack, ib.rdata} !== {1'b1, 32'h1234}) begin n_err++; $display("FAIL tie_i_ack got %0h exp %0h", {ib.ack, ib.rdata}, {1'b1, 32'h1234}); end
    next(); mem.ack = 0; ib.req = 0;
    mid();
  endtask

  task automatic test_contention();
    bit own[$];
    int cyc[$];
    next(); ib.req = 1; ib.addr = 32'h100; db.req = 1; db.addr = 32'h200; mem.ack = 0;
    mid();
    for (int c = 0; c < 40 && own.size() < 6; c++) begin
      next(); mem.ack = mem.req; mem.rdata = 32'(c);
      mid();
      if (ib.ack) begin own.push_back(1'b0); cyc.push_back(c); end
      if (db.ack) begin own.push_back(1'b1); cyc.push_back(c); end
    end
    n_cmp++; if (own.size() != 6) begin n_err++; $display("FAIL cont_count got %0d exp 6", own.size()); end
    for (int k = 0; k < own.size(); k++) begin
      n_cmp++; if (own[k] !== ((k % 2) == 0)) begin n_err++; $display("FAIL cont_owner[%0d] got %0d exp %0d", k, own[k], (k % 2) == 0); end
      if (k > 0) begin
        n_cmp++; if (cyc[k] - cyc[k-1] != 2) begin n_err++; $display("FAIL cont_gap[%0d] got %0d exp 2", k, cyc[k] - cyc[k-1]); end
      end
    end
    next(); ib.req = 0; db.req = 0; mem.ack = 0;
    mid();
  endtask

  task automatic test_stability();
    next(); db.req = 1; db.wr = 1; db.addr = 32'h2000; db.wdata = 32'hA5A5A5A5; db.wsel = 4'h3;
    next(); db.addr = 32'h12345678; db.wdata = 32'h0; db.wsel = 4'hC;
    mid();
    n_cmp++; if ({mem.addr, mem.wsel} !== {32'h2000, 4'h3}) begin n_err++; $display("FAIL stab_hold1 got %0h exp %0h", {mem.addr, mem.wsel}, {32'h2000, 4'h3}); end
    next(); mid();
    n_cmp++; if (mem.addr !== 32'h2000) begin n_err++; $display("FAIL stab_hold2 got %0h exp 2000", mem.addr); end
    next(); mem.ack = 1;
    mid();
    n_cmp++; if ({db.ack, mem.addr, mem.wdata} !== {1'b1, 32'h2000, 32'hA5A5A5A5}) begin n_err++; $display("FAIL stab_ack got %0h exp %0h", {db.ack, mem.addr, mem.wdata}, {1'b1, 32'h2000, 32'hA5A5A5A5}); end
    next(); mem.ack = 0; db.req = 0; db.wr = 0;
    mid();
    n_cmp++; if (mem.req !== 1'b0) begin n_err++; $display("FAIL stab_done got %0h exp 0", mem.req); end
  endtask

  task automatic test_spurious();
    next(); mem.ack = 1; mem.rdata = 32'hFFFFFFFF;
    mid();
    n_cmp++; if ({ib.ack, db.ack, ib.rdata, db.rdata} !== '0) begin n_err++; $display("FAIL spur_resp got %0h exp 0", {ib.ack, db.ack, ib.rdata, db.rdata}); end
    next(); mid();
    n_cmp++; if ({mem.req, ib.ack, db.ack} !== 3'b000) begin n_err++; $display("FAIL spur_idle got %0h exp 0", {mem.req, ib.ack, db.ack}); end
    next(); mem.ack = 0; mem.rdata = '0; ib.req = 1; ib.addr = 32'h300; db.req = 1; db.addr = 32'h400;
    next(); mid();
    n_cmp++; if ({mem.req, mem.addr} !== {1'b1, 32'h300}) begin n_err++; $display("FAIL spur_rr_kept got %0h exp %0h", {mem.req, mem.addr}, {1'b1, 32'h300}); end
    next(); mem.ack = 1;
    mid();
    n_cmp++; if ({ib.ack, db.ack} !== 2'b10) begin n_err++; $display("FAIL spur_i_ack got %0h exp 2", {ib.ack, db.ack}); end
    next(); mem.ack = 0; ib.req = 0; db.req = 0;
    mid();
  endtask

  task automatic test_reset_mid();
    next(); ib.req = 1; ib.addr = 32'h500;
    next(); mid();
    n_cmp++; if (mem.req !== 1'b1) begin n_err++; $display("FAIL rstm_grant got %0h exp 1", mem.req); end
    next(); rst = 1;
    #1;
    n_cmp++; if ({mem.req, mem.addr} !== '0) begin n_err++; $display("FAIL rstm_async got %0h exp 0", {mem.req, mem.addr}); end
    mem.ack = 1; mem.rdata = 32'hCAFE;
    mid();
    n_cmp++; if ({ib.ack, ib.rdata} !== '0) begin n_err++; $display("FAIL rstm_no_ack got %0h exp 0", {ib.ack, ib.rdata}); end
    next(); rst = 0; mem.ack = 0; mem.rdata = '0; ib.req = 0;
    next(); ib.req = 1; ib.addr = 32'h600; db.req = 1; db.addr = 32'h700; db.wr = 1;
    next(); mid();
    n_cmp++; if ({mem.req, mem.wr, mem.addr} !== {1'b1, 1'b1, 32'h700}) begin n_err++; $display("FAIL rstm_tie_d got %0h exp %0h", {mem.req, mem.wr, mem.addr}, {1'b1, 1'b1, 32'h700}); end
    next(); mem.ack = 1;
    mid();
    n_cmp++; if ({db.ack, ib.ack} !== 2'b10) begin n_err++; $display("FAIL rstm_d_ack got %0h exp 2", {db.ack, ib.ack}); end
    next(); mem.ack = 0; ib.req = 0; db.req = 0; db.wr = 0;
    mid();
  endtask

  // reference: a transaction is either in flight (owner + captured fields) or not
  task automatic test_random();
    bit ip = 0, dp = 0, busy = 0, own = 0, last = 0, win, ea_i, ea_d;
    logic m_wr;
    logic [31:0] m_addr, m_wdata;
    logic [3:0] m_wsel;
    next(); rst = 1; drive_idle();
    next(); rst = 0;
    m_wr = 0; m_addr = '0; m_wdata = '0; m_wsel = '0;
    for (int c = 0; c < 3000; c++) begin
      next();
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; ib.wr = 1'($urandom); ib.addr = $urandom; ib.wdata = $urandom; ib.wsel = 4'($urandom);
      end else if (ip && $urandom_range(0, 7) == 0) ib.addr = $urandom;
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; db.wr = 1'($urandom); db.addr = $urandom; db.wdata = $urandom; db.wsel = 4'($urandom);
      end else if (dp && $urandom_range(0, 7) == 0) db.addr = $urandom;
      ib.req = ip; db.req = dp;
      mem.ack = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      mem.rdata = $urandom;
      mid();
      ea_i = busy && !own && mem.ack;
      ea_d = busy && own && mem.ack;
      n_cmp++; if (mem.req !== busy) begin n_err++; $display("FAIL rnd_req c=%0d got %0h exp %0h", c, mem.req, busy); end
      if (busy) begin
        n_cmp++; if ({mem.wr, mem.addr, mem.wdata, mem.wsel} !== {m_wr, m_addr, m_wdata, m_wsel}) begin n_err++; $display("FAIL rnd_fields c=%0d got %0h exp %0h", c, {mem.wr, mem.addr, mem.wdata, mem.wsel}, {m_wr, m_addr, m_wdata, m_wsel}); end
      end
      n_cmp++; if ({ib.ack, ib.rdata} !== {ea_i, ea_i ? mem.rdata : 32'h0}) begin n_err++; $display("FAIL rnd_i c=%0d got %0h exp %0h", c, {ib.ack, ib.rdata}, {ea_i, ea_i ? mem.rdata : 32'h0}); end
      n_cmp++; if ({db.ack, db.rdata} !== {ea_d, ea_d ? mem.rdata : 32'h0}) begin n_err++; $display("FAIL rnd_d c=%0d got %0h exp %0h", c, {db.ack, db.rdata}, {ea_d, ea_d ? mem.rdata : 32'h0}); end
      if (ea_i) ip = 0;
      if (ea_d) dp = 0;
      if (busy) begin
        if (mem.ack) busy = 0;
      end else if (ib.req || db.req) begin
        win = (ib.req && db.req) ? !last : db.req;
        busy = 1; own = win; last = win;
        m_wr = win ? db.wr : ib.wr;
        m_addr = win ? db.addr : ib.addr;
        m_wdata = win ? db.wdata : ib.wdata;
        m_wsel = win ? db.wsel : ib.wsel;
      end
    end
    next(); drive_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lone_read();
    test_tie();
    test_contention();
    test_stability();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
